// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the handshaked MEM stage.
// Contents: data/address widths, funct3 size codes, FSM state encoding,
// and the store-strobe / load-extension helpers used by mem_lane_align.
package mem_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned RADDR_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {StIdle, StReq, StWait} mem_state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

  // Unlisted funct3 codes fall back to a word access.
  function automatic mem_size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SzByte;
      F3_H, F3_HU: size_of = SzHalf;
      default:     size_of = SzWord;
    endcase
  endfunction

  // Byte offset after forcing natural alignment (H drops a[0], W drops a[1:0]).
  function automatic logic [1:0] natural_off(input mem_size_e sz, input logic [1:0] a);
    case (sz)
      SzByte:  natural_off = a;
      SzHalf:  natural_off = {a[1], 1'b0};
      default: natural_off = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input mem_size_e sz, input logic [1:0] off);
    case (sz)
      SzByte:  store_strb = 4'b0001 << off;
      SzHalf:  store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_ext(input mem_size_e sz, input logic sext,
                                               input logic [1:0] off,
                                               input logic [XLEN-1:0] word);
    logic [XLEN-1:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SzByte:  load_ext = {{24{sext & sh[7]}}, sh[7:0]};
      SzHalf:  load_ext = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// mem_stage_hs_if: data-memory request/response bus.
// master (MEM stage): drives dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata;
//                     receives dmem_req_ready, dmem_rsp_valid, dmem_rdata.
// slave  (memory):    the reverse.
interface mem_stage_hs_if;
  import mem_pkg::*;

  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic [ADDR_W-1:0]     dmem_addr;
  logic                  dmem_we;
  logic [3:0]            dmem_wstrb;
  logic [XLEN-1:0]       dmem_wdata;
  logic                  dmem_rsp_valid;
  logic [XLEN-1:0]       dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for stores and
// sign/zero extension for loads.
// Ports: funct3_i (size/sign), addr_lo_i (byte offset), store_data_i (unaligned
// store data), rdata_i (raw read word) -> wstrb_o, wdata_o (lane-replicated),
// load_data_o (extended load value).
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_data_o
);

  mem_size_e  size;
  logic [1:0] off;

  always_comb begin
    size        = size_of(funct3_i);
    off         = natural_off(size, addr_lo_i);
    wstrb_o     = store_strb(size, off);
    load_data_o = load_ext(size, ~funct3_i[2], off, rdata_i);
    case (size)
      SzByte:  wdata_o = {4{store_data_i[7:0]}};
      SzHalf:  wdata_o = {2{store_data_i[15:0]}};
      default: wdata_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage with valid/ready data-memory handshake and
// variable response latency; one outstanding access at a time.
// Ports: clk, rst_n (async, active-low); ex_mem_* from the EX/MEM register;
// mem_stall back to the upstream stages; dmem (mem_stage_hs_if.master) to data
// memory; mem_wb_* registered outputs to WB.
// Build option: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned H/W
// accesses instead of truncating them to natural alignment.
module mem_stage_hs
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_mem_valid,
  input  logic [ADDR_W-1:0]  ex_mem_alu_result,
  input  logic [XLEN-1:0]    ex_mem_rs2_data,
  input  logic [RADDR_W-1:0] ex_mem_rd_addr,
  input  logic               ex_mem_reg_write_en,
  input  logic               ex_mem_mem_read_en,
  input  logic               ex_mem_mem_write_en,
  input  logic [1:0]         ex_mem_mem_to_reg,
  input  logic [2:0]         ex_mem_funct3,
  output logic               mem_stall,
  mem_stage_hs_if.master     dmem,
  output logic               mem_wb_valid,
  output logic [XLEN-1:0]    mem_wb_dmem_data_out,
  output logic [XLEN-1:0]    mem_wb_alu_result,
  output logic [RADDR_W-1:0] mem_wb_rd_addr,
  output logic               mem_wb_reg_write_en,
  output logic [1:0]         mem_wb_mem_to_reg,
  output logic               mem_wb_misalign
);

  mem_state_e         state_q;
  logic               wb_valid_q, wb_rwe_q, wb_mis_q;
  logic [XLEN-1:0]    wb_data_q, wb_alu_q;
  logic [RADDR_W-1:0] wb_rd_q;
  logic [1:0]         wb_m2r_q;

  logic            mem_op, misalign, issue, rsp_done;
  logic [XLEN-1:0] load_data;

  assign mem_op = ex_mem_valid & (ex_mem_mem_read_en | ex_mem_mem_write_en);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  mem_size_e size;
  assign size     = size_of(ex_mem_funct3);
  assign misalign = mem_op & (((size == SzHalf) & ex_mem_alu_result[0]) |
                              ((size == SzWord) & (|ex_mem_alu_result[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign issue    = mem_op & ~misalign;
  assign rsp_done = (state_q == StWait) & dmem.dmem_rsp_valid;

  // Gated with rst_n so these combinational outputs read 0 while reset is held.
  assign mem_stall           = rst_n & issue & ~rsp_done;
  assign dmem.dmem_req_valid = rst_n & (((state_q == StIdle) & issue) | (state_q == StReq));
  assign dmem.dmem_addr      = {ex_mem_alu_result[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_we        = ex_mem_mem_write_en;

  mem_lane_align u_lane_align (
    .funct3_i     (ex_mem_funct3),
    .addr_lo_i    (ex_mem_alu_result[1:0]),
    .store_data_i (ex_mem_rs2_data),
    .rdata_i      (dmem.dmem_rdata),
    .wstrb_o      (dmem.dmem_wstrb),
    .wdata_o      (dmem.dmem_wdata),
    .load_data_o  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wb_valid_q <= 1'b0;
      wb_rwe_q   <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_alu_q   <= '0;
      wb_rd_q    <= '0;
      wb_m2r_q   <= '0;
    end else begin
      case (state_q)
        StIdle:  if (issue) state_q <= dmem.dmem_req_ready ? StWait : StReq;
        StReq:   if (dmem.dmem_req_ready) state_q <= StWait;
        StWait:  if (dmem.dmem_rsp_valid) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (mem_stall || !ex_mem_valid) begin
        // Bubble: only valid and write-enable drop; the rest hold.
        wb_valid_q <= 1'b0;
        wb_rwe_q   <= 1'b0;
      end else begin
        wb_valid_q <= 1'b1;
        wb_alu_q   <= ex_mem_alu_result;
        wb_rd_q    <= ex_mem_rd_addr;
        wb_rwe_q   <= ex_mem_reg_write_en & ~misalign;
        wb_m2r_q   <= ex_mem_mem_to_reg;
        wb_mis_q   <= misalign;
        if (rsp_done && ex_mem_mem_read_en) wb_data_q <= load_data;
      end
    end
  end

  assign mem_wb_valid         = wb_valid_q;
  assign mem_wb_dmem_data_out = wb_data_q;
  assign mem_wb_alu_result    = wb_alu_q;
  assign mem_wb_rd_addr       = wb_rd_q;
  assign mem_wb_reg_write_en  = wb_rwe_q;
  assign mem_wb_mem_to_reg    = wb_m2r_q;
  assign mem_wb_misalign      = wb_mis_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: directed accesses with scripted memory timing;
// expected WB results are queued at issue and checked by an independent monitor.
module tb_mem_stage_hs;

  logic        clk;
  logic        rst_n;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_rs2_data;
  logic [4:0]  ex_mem_rd_addr;
  logic        ex_mem_reg_write_en;
  logic        ex_mem_mem_read_en;
  logic        ex_mem_mem_write_en;
  logic [1:0]  ex_mem_mem_to_reg;
  logic [2:0]  ex_mem_funct3;
  logic        mem_stall;
  logic        mem_wb_valid;
  logic [31:0] mem_wb_dmem_data_out;
  logic [31:0] mem_wb_alu_result;
  logic [4:0]  mem_wb_rd_addr;
  logic        mem_wb_reg_write_en;
  logic [1:0]  mem_wb_mem_to_reg;
  logic        mem_wb_misalign;

  mem_stage_hs_if dmem_if ();

  mem_stage_hs dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_mem_valid         (ex_mem_valid),
    .ex_mem_alu_result    (ex_mem_alu_result),
    .ex_mem_rs2_data      (ex_mem_rs2_data),
    .ex_mem_rd_addr       (ex_mem_rd_addr),
    .ex_mem_reg_write_en  (ex_mem_reg_write_en),
    .ex_mem_mem_read_en   (ex_mem_mem_read_en),
    .ex_mem_mem_write_en  (ex_mem_mem_write_en),
    .ex_mem_mem_to_reg    (ex_mem_mem_to_reg),
    .ex_mem_funct3        (ex_mem_funct3),
    .mem_stall            (mem_stall),
    .dmem                 (dmem_if),
    .mem_wb_valid         (mem_wb_valid),
    .mem_wb_dmem_data_out (mem_wb_dmem_data_out),
    .mem_wb_alu_result    (mem_wb_alu_result),
    .mem_wb_rd_addr       (mem_wb_rd_addr),
    .mem_wb_reg_write_en  (mem_wb_reg_write_en),
    .mem_wb_mem_to_reg    (mem_wb_mem_to_reg),
    .mem_wb_misalign      (mem_wb_misalign)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rwe;
    logic [1:0]  m2r;
    logic        mis;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per WB-valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wb_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL wb_unexpected: got mem_wb_valid=1 expected 0 (no pending op)");
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_alu", mem_wb_alu_result, mon_e.alu);
          chk("wb_rd", {27'd0, mem_wb_rd_addr}, {27'd0, mon_e.rd});
          chk("wb_rwe", {31'd0, mem_wb_reg_write_en}, {31'd0, mon_e.rwe});
          chk("wb_m2r", {30'd0, mem_wb_mem_to_reg}, {30'd0, mon_e.m2r});
          chk("wb_misalign", {31'd0, mem_wb_misalign}, {31'd0, mon_e.mis});
          if (mon_e.chk_data) chk("wb_data", mem_wb_dmem_data_out, mon_e.data);
        end
      end else begin
        chk("bubble_rwe", {31'd0, mem_wb_reg_write_en}, 32'd0);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       input logic rd_en, input logic wr_en, input logic [4:0] rd,
                       input logic rwe, input logic [1:0] m2r);
    ex_mem_valid        = 1'b1;
    ex_mem_alu_result   = a;
    ex_mem_rs2_data     = d;
    ex_mem_funct3       = f3;
    ex_mem_mem_read_en  = rd_en;
    ex_mem_mem_write_en = wr_en;
    ex_mem_rd_addr      = rd;
    ex_mem_reg_write_en = rwe;
    ex_mem_mem_to_reg   = m2r;
  endtask

  task automatic idle_inputs();
    ex_mem_valid        = 1'b0;
    ex_mem_mem_read_en  = 1'b0;
    ex_mem_mem_write_en = 1'b0;
    ex_mem_reg_write_en = 1'b0;
  endtask

  task automatic chk_req(input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb);
    chk("req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd1);
    chk("req_addr", dmem_if.dmem_addr, e_addr);
    chk("req_we", {31'd0, dmem_if.dmem_we}, {31'd0, e_we});
    if (e_we) begin
      chk("req_wdata", dmem_if.dmem_wdata, e_wdata);
      chk("req_wstrb", {28'd0, dmem_if.dmem_wstrb}, {28'd0, e_wstrb});
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic mem_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            input logic wr_en, input logic [4:0] rd, input logic rwe,
                            input int ready_lo, input int rsp_wait, input logic [31:0] rdata,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_wstrb, input logic [31:0] e_data);
    int stall_cnt;
    exp_t e;
    stall_cnt = 0;
    drive(a, d, f3, ~wr_en, wr_en, rd, rwe, 2'b01);
    e = '{data: e_data, alu: a, rd: rd, rwe: rwe, m2r: 2'b01, mis: 1'b0, chk_data: ~wr_en};
    exp_q.push_back(e);
    dmem_if.dmem_req_ready = 1'b0;
    for (int k = 0; k < ready_lo; k++) begin
      @(negedge clk);
      chk_req(e_addr, wr_en, e_wdata, e_wstrb);
      if (mem_stall) stall_cnt++;
      @(posedge clk); #1;
    end
    dmem_if.dmem_req_ready = 1'b1;
    @(negedge clk);
    chk_req(e_addr, wr_en, e_wdata, e_wstrb);
    if (mem_stall) stall_cnt++;
    @(posedge clk); #1;
    dmem_if.dmem_req_ready = 1'b0;
    for (int k = 0; k < rsp_wait; k++) begin
      @(negedge clk);
      chk("wait_req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
      if (mem_stall) stall_cnt++;
      @(posedge clk); #1;
    end
    dmem_if.dmem_rsp_valid = 1'b1;
    dmem_if.dmem_rdata     = rdata;
    @(negedge clk);
    chk("rsp_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rdata     = 32'h0;
    idle_inputs();
    chk("stall_cycles", stall_cnt, 1 + ready_lo + rsp_wait);
    @(negedge clk);
    chk("wb_valid_after_rsp", {31'd0, mem_wb_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Single-cycle op (no request): ALU op or trapped misaligned access.
  task automatic quick_op(input logic [31:0] a, input logic [2:0] f3, input logic rd_en,
                          input logic [4:0] rd, input logic rwe, input logic [1:0] m2r,
                          input logic e_rwe, input logic e_mis);
    exp_t e;
    drive(a, 32'h0, f3, rd_en, 1'b0, rd, rwe, m2r);
    e = '{data: 32'h0, alu: a, rd: rd, rwe: e_rwe, m2r: m2r, mis: e_mis, chk_data: 1'b0};
    exp_q.push_back(e);
    @(negedge clk);
    chk("quick_stall", {31'd0, mem_stall}, 32'd0);
    chk("quick_req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("quick_wb_valid", {31'd0, mem_wb_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, {31'd0, mem_wb_valid}, 32'd0);
    chk({tag, "_wb_data"}, mem_wb_dmem_data_out, 32'd0);
    chk({tag, "_wb_alu"}, mem_wb_alu_result, 32'd0);
    chk({tag, "_wb_rd"}, {27'd0, mem_wb_rd_addr}, 32'd0);
    chk({tag, "_wb_rwe"}, {31'd0, mem_wb_reg_write_en}, 32'd0);
    chk({tag, "_wb_m2r"}, {30'd0, mem_wb_mem_to_reg}, 32'd0);
    chk({tag, "_wb_mis"}, {31'd0, mem_wb_misalign}, 32'd0);
    chk({tag, "_req_valid"}, {31'd0, dmem_if.dmem_req_valid}, 32'd0);
    chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    ex_mem_alu_result = 32'h0;
    ex_mem_rs2_data   = 32'h0;
    ex_mem_rd_addr    = 5'd0;
    ex_mem_mem_to_reg = 2'b00;
    ex_mem_funct3     = 3'b000;
    idle_inputs();
    dmem_if.dmem_req_ready = 1'b0;
    dmem_if.dmem_rsp_valid = 1'b0;
    dmem_if.dmem_rdata     = 32'h0;

    @(posedge clk); #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW a=0x100: stall for 3 cycles before the ack
    mem_access(32'h100, 32'hDEADBEEF, 3'b010, 1'b1, 5'd0, 1'b0, 0, 2, 32'h0,
               32'h100, 32'hDEADBEEF, 4'b1111, 32'h0);
    // LB / LBU a=0x103 rdata=0x80FF0000
    mem_access(32'h103, 32'h0, 3'b000, 1'b0, 5'd3, 1'b1, 0, 0, 32'h80FF_0000,
               32'h100, 32'h0, 4'b0000, 32'hFFFFFF80);
    mem_access(32'h103, 32'h0, 3'b100, 1'b0, 5'd4, 1'b1, 0, 1, 32'h80FF_0000,
               32'h100, 32'h0, 4'b0000, 32'h00000080);
    // LHU / LH a=0x102 rdata=0xBEEF1234
    mem_access(32'h102, 32'h0, 3'b101, 1'b0, 5'd6, 1'b1, 1, 0, 32'hBEEF1234,
               32'h100, 32'h0, 4'b0000, 32'h0000BEEF);
    mem_access(32'h102, 32'h0, 3'b001, 1'b0, 5'd7, 1'b1, 0, 0, 32'hBEEF1234,
               32'h100, 32'h0, 4'b0000, 32'hFFFFBEEF);
    // SH a=0x102 with ready low for 3 cycles; request must hold stable
    mem_access(32'h102, 32'h0000ABCD, 3'b001, 1'b1, 5'd0, 1'b0, 3, 0, 32'h0,
               32'h100, 32'hABCDABCD, 4'b1100, 32'h0);
    // SB a=0x101
    mem_access(32'h101, 32'h1234565A, 3'b000, 1'b1, 5'd0, 1'b0, 1, 1, 32'h0,
               32'h100, 32'h5A5A5A5A, 4'b0010, 32'h0);
    // ALU op rd=5
    quick_op(32'h0000_0042, 3'b000, 1'b0, 5'd5, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("alu_rd", {27'd0, mem_wb_rd_addr}, 32'd5);

    // Spurious response while idle
    dmem_if.dmem_rsp_valid = 1'b1;
    dmem_if.dmem_rdata     = 32'hCAFEF00D;
    @(negedge clk);
    chk("spur_req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    dmem_if.dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("spur_wb_valid", {31'd0, mem_wb_valid}, 32'd0);
    @(posedge clk); #1;

    // Misaligned LW a=0x101
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    quick_op(32'h101, 3'b010, 1'b1, 5'd9, 1'b1, 2'b01, 1'b0, 1'b1);
`else
    mem_access(32'h101, 32'h0, 3'b010, 1'b0, 5'd9, 1'b1, 0, 0, 32'h11223344,
               32'h100, 32'h0, 4'b0000, 32'h11223344);
`endif

    // Reset while waiting for a response
    drive(32'h200, 32'h0, 3'b010, 1'b1, 1'b0, 5'd10, 1'b1, 2'b01);
    dmem_if.dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_if.dmem_req_ready = 1'b0;
    @(negedge clk);
    chk("wait_stall", {31'd0, mem_stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_if.dmem_rsp_valid = 1'b1;
    dmem_if.dmem_rdata     = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rsp_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_if.dmem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_wb_valid", {31'd0, mem_wb_valid}, 32'd0);
    @(posedge clk); #1;

    // Normal operation afterwards
    mem_access(32'h203, 32'h0, 3'b100, 1'b0, 5'd11, 1'b1, 0, 1, 32'h7F00_0000,
               32'h200, 32'h0, 4'b0000, 32'h0000007F);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
